munoc_ordered_lane_gather: RTL
==============================

MUNOC_ORDERED_LANE_GATHER -- requirements
Module: munoc_ordered_lane_gather

Interface
REQ-001 Parameter BW_DATA, default 32: width of one data word.
REQ-002 Parameter NUM_LANE, default 4: number of lanes gathered; SHALL be >=2.
REQ-003 Parameter STALL_LIMIT, default 16: stall-cycle threshold for the stalled flag; SHALL be >=1.
REQ-004 Parameter BW_STALL, default 8: stall counter width; STALL_LIMIT SHALL be <= 2^BW_STALL-1.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rstnn  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  permits new lane pops when high.
REQ-008 init  input  1  synchronous restart pulse.
REQ-009 lane_ready  input  NUM_LANE  bit i high: lane i holds a word.
REQ-010 lane_request  output  NUM_LANE  bit i high: pop lane i this cycle.
REQ-011 lane_data  input  NUM_LANE*BW_DATA  lane i word at bits [BW_DATA*(i+1)-1 -: BW_DATA].
REQ-012 out_valid  output  1  out_data holds a word.
REQ-013 out_ready  input  1  consumer accepts the word.
REQ-014 out_data  output  BW_DATA  gathered word.
REQ-015 lane_index  output  ceil(log2(NUM_LANE))  current lane pointer.
REQ-016 stalled  output  1  stall counter >= STALL_LIMIT.

Function
REQ-017 The block SHALL restore strict rotation order: lanes popped 0,1,...,NUM_LANE-1,0,... with no lane skipped.
REQ-018 The output stage SHALL be a single register; "slot free" = !out_valid | out_ready.
REQ-019 pop = enable & !init & lane_ready[ptr] & slot free; lane_request SHALL be combinational, one-hot at ptr when pop, else all zero.
REQ-020 On pop, out_data SHALL load lane_data[ptr] and out_valid SHALL be 1 the next cycle (latency 1).
REQ-021 On out_valid & out_ready without pop, out_valid SHALL clear next cycle; with pop, out_valid SHALL stay 1, giving one word per cycle.
REQ-022 On pop, ptr SHALL advance by 1, wrapping NUM_LANE-1 -> 0.
REQ-023 FSM states: IDLE, RUN, WAIT.
REQ-024 IDLE -> RUN when enable & !init; any state -> IDLE when !enable or init.
REQ-025 RUN -> WAIT when lane_ready[ptr]=0 while the slot is free; WAIT -> RUN on the cycle a pop occurs.
REQ-026 In WAIT, the stall counter SHALL increment each cycle that lane_ready[ptr]=0 and any other lane_ready bit is 1, saturating at 2^BW_STALL-1.
REQ-027 The stall counter SHALL clear on pop, init, or entry to IDLE.
REQ-028 stalled SHALL be a registered compare of the counter against STALL_LIMIT.
REQ-029 Backpressure (out_ready=0 with out_valid=1) SHALL NOT count as a stall and SHALL hold out_data stable.
REQ-030 With enable=0, no pops SHALL occur; a held output word SHALL remain valid until accepted.
REQ-031 init SHALL take priority over everything: no pop that cycle; next cycle ptr=0, out_valid=0, counter=0, state IDLE; a held output word is discarded.
REQ-032 lane_ready on lanes other than ptr SHALL never cause a pop.

Reset
REQ-033 While rstnn=0: ptr=0, out_valid=0, out_data=0, stall counter=0, stalled=0, state IDLE, lane_request=0.
REQ-034 Reset deassertion mid-stream SHALL resume from lane 0; prior lane contents are not the block's concern.

Verification
REQ-035 NUM_LANE=4, all lanes ready, out_ready=1, enable=1 -> pops on lanes 0,1,2,3,0 on consecutive cycles; out_valid high from cycle 2 onward, one word per cycle in lane order.
REQ-036 Lane 1 empty for 20 cycles while lanes 2,3 are ready, STALL_LIMIT=16 -> no pop on lanes 2 or 3; stalled=1 from the 17th stall cycle; counter clears on the lane 1 pop.
REQ-037 out_ready=0 for 5 cycles after the first word -> out_data unchanged, no further pops, stalled stays 0.
REQ-038 init pulsed while ptr=2 and out_valid=1 -> next cycle out_valid=0, lane_index=0; the next pop is lane 0.
REQ-039 enable dropped with a word held, then out_ready=1 -> the word is delivered once, no new pop, state IDLE.
REQ-040 rstnn asserted mid-transfer -> all outputs zero immediately, asynchronously; after release, the first pop is lane 0.

Source files
------------

// File: rtl/munoc_ordered_lane_gather.sv
// Gathers words from NUM_LANE lane buffers in strict round-robin order into a
// single-register output stage. Also flags lanes that starve the rotation.
module munoc_ordered_lane_gather #(
  parameter int BW_DATA     = 32,
  parameter int NUM_LANE    = 4,
  parameter int STALL_LIMIT = 16,
  parameter int BW_STALL    = 8,
  localparam int BW_INDEX   = $clog2(NUM_LANE)
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic                        enable,
  input  logic                        init,
  input  logic [NUM_LANE-1:0]         lane_ready,
  output logic [NUM_LANE-1:0]         lane_request,
  input  logic [NUM_LANE*BW_DATA-1:0] lane_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BW_DATA-1:0]          out_data,
  output logic [BW_INDEX-1:0]         lane_index,
  output logic                        stalled
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT
  } state_t;

  localparam logic [BW_INDEX-1:0] LAST_LANE     = BW_INDEX'(NUM_LANE - 1);
  localparam logic [BW_STALL-1:0] STALL_MAX     = {BW_STALL{1'b1}};
  localparam logic [BW_STALL-1:0] STALL_LIMIT_W = BW_STALL'(STALL_LIMIT);

  state_t               state_reg, state_next;
  logic [BW_INDEX-1:0]  ptr_reg, ptr_next;
  logic                 out_valid_reg;
  logic [BW_DATA-1:0]   out_data_reg;
  logic [BW_STALL-1:0]  stall_cnt_reg, stall_cnt_next;
  logic                 stalled_reg;

  logic [BW_DATA-1:0]   lane_word [NUM_LANE];
  logic [NUM_LANE-1:0]  ptr_onehot;
  logic [BW_DATA-1:0]   head_word;
  logic                 head_ready;
  logic                 other_ready;
  logic                 slot_free;
  logic                 pop;
  logic                 stall_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANE; gi++) begin : g_lane
      assign lane_word[gi]  = lane_data[BW_DATA*(gi+1)-1 -: BW_DATA];
      assign ptr_onehot[gi] = (ptr_reg == BW_INDEX'(gi));
    end
  endgenerate

  always_comb begin
    head_word = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (ptr_onehot[i]) head_word = head_word | lane_word[i];
    end
  end

  assign head_ready  = |(lane_ready & ptr_onehot);
  assign other_ready = |(lane_ready & ~ptr_onehot);
  assign slot_free   = !out_valid_reg || out_ready;
  // rstnn gates the pop so lane_request is forced low during reset
  assign pop = rstnn && enable && !init && head_ready && slot_free;

  // State register
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (!enable || init) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN:  if (!head_ready && slot_free) state_next = ST_WAIT;
        ST_WAIT: if (pop) state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    lane_request = pop ? ptr_onehot : '0;
    stall_inc    = (state_reg == ST_WAIT) && !head_ready && other_ready && slot_free;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (init)     ptr_next = '0;
    else if (pop) ptr_next = (ptr_reg == LAST_LANE) ? '0 : ptr_reg + 1'b1;
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (pop || init || state_next == ST_IDLE)
      stall_cnt_next = '0;
    else if (stall_inc && stall_cnt_reg != STALL_MAX)
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      ptr_reg       <= '0;
      stall_cnt_reg <= '0;
      stalled_reg   <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      stall_cnt_reg <= stall_cnt_next;
      stalled_reg   <= (stall_cnt_next >= STALL_LIMIT_W);
    end
  end

  // Output register: a pop refills it in the same cycle the old word leaves
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (init) begin
      out_valid_reg <= 1'b0;
    end else if (pop) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= head_word;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign lane_index = ptr_reg;
  assign stalled    = stalled_reg;

endmodule
